// File: rtl/loop_track_buffer.sv
// Stereo loop recorder/player: records live frames into an on-chip buffer, plays the
// loop back mixed (saturating) with live audio, and can overdub the mix into the loop.
module loop_track_buffer #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              AUD_BCLK,
  input  logic              reset,
  input  logic              AUD_DACLRCK,
  input  logic [DATA_W-1:0] left_channel_audio_in,
  input  logic [DATA_W-1:0] right_channel_audio_in,
  input  logic              cmd_record,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  output logic [DATA_W-1:0] left_channel_audio_out,
  output logic [DATA_W-1:0] right_channel_audio_out,
  output logic [1:0]        loop_state,
  output logic [ADDR_W:0]   loop_length,
  output logic [ADDR_W-1:0] loop_position
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] POS_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RECORD  = 2'b01,
    ST_PLAY    = 2'b10,
    ST_OVERDUB = 2'b11
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   position, pos_next;
  logic [ADDR_W:0]     len_next;
  logic                lrck_d;
  logic                tick;
  logic                rd_en;
  logic                rec_write, od_write, wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [2*DATA_W-1:0] wr_data;
  logic [2*DATA_W-1:0] rd_data;
  logic [2*DATA_W-1:0] mem [DEPTH];

  // Read issued at the tick completes one cycle later; these carry it to T+1.
  logic                pend, pend_od;
  logic [ADDR_W-1:0]   pend_addr;
  logic [DATA_W-1:0]   live_l_q, live_r_q;
  logic [DATA_W-1:0]   mix_l, mix_r;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1])
      sat_add = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_add = sum[DATA_W-1:0];
  endfunction

  assign tick          = AUD_DACLRCK & ~lrck_d;
  assign loop_state    = state;
  assign loop_position = position;

  assign mix_l = sat_add(live_l_q, rd_data[2*DATA_W-1:DATA_W]);
  assign mix_r = sat_add(live_r_q, rd_data[DATA_W-1:0]);

  assign rec_write = (state == ST_RECORD) && tick;
  assign od_write  = pend && pend_od;
  assign wr_en     = reset && (rec_write || od_write);
  assign wr_addr   = od_write ? pend_addr : position;
  assign wr_data   = od_write ? {mix_l, mix_r}
                              : {left_channel_audio_in, right_channel_audio_in};

  // The tick is applied first under the current state; a command then overrides.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_next = state;
    pos_next   = position;
    len_next   = loop_length;
    rd_en      = 1'b0;

    unique case (state)
      ST_IDLE: ;
      ST_RECORD: begin
        if (tick) begin
          len_next = {1'b0, position} + LEN_ONE;
          if (position == '1) begin
            state_next = ST_PLAY;
            pos_next   = '0;
          end else begin
            pos_next = position + POS_ONE;
          end
        end
      end
      ST_PLAY, ST_OVERDUB: begin
        if (tick) begin
          rd_en = 1'b1;
          if ({1'b0, position} + LEN_ONE == loop_length) pos_next = '0;
          else                                          pos_next = position + POS_ONE;
        end
      end
    endcase

    if (cmd_stop) begin
      state_next = ST_IDLE;
    end else if (cmd_record) begin
      case (state)
        ST_IDLE: begin
          state_next = ST_RECORD;
          pos_next   = '0;
          len_next   = '0;
        end
        ST_PLAY:    state_next = ST_OVERDUB;
        ST_OVERDUB: state_next = ST_PLAY;
        default: ;
      endcase
    end else if (cmd_play) begin
      case (state)
        ST_IDLE: begin
          if (loop_length != '0) begin
            state_next = ST_PLAY;
            pos_next   = '0;
          end
        end
        ST_RECORD: begin
          state_next = (len_next != '0) ? ST_PLAY : ST_IDLE;
          pos_next   = '0;
        end
        ST_OVERDUB: state_next = ST_PLAY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge AUD_BCLK) begin
    if (!reset) begin
      state                   <= ST_IDLE;
      position                <= '0;
      loop_length             <= '0;
      lrck_d                  <= 1'b0;
      pend                    <= 1'b0;
      pend_od                 <= 1'b0;
      pend_addr               <= '0;
      live_l_q                <= '0;
      live_r_q                <= '0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else begin
      lrck_d      <= AUD_DACLRCK;
      state       <= state_next;
      position    <= pos_next;
      loop_length <= len_next;
      pend        <= rd_en;
      pend_od     <= rd_en && (state == ST_OVERDUB);
      if (rd_en) begin
        pend_addr <= position;
        live_l_q  <= left_channel_audio_in;
        live_r_q  <= right_channel_audio_in;
      end
      if (pend) begin
        left_channel_audio_out  <= mix_l;
        right_channel_audio_out <= mix_r;
      end else if (tick && (state == ST_IDLE || state == ST_RECORD)) begin
        left_channel_audio_out  <= left_channel_audio_in;
        right_channel_audio_out <= right_channel_audio_in;
      end
    end
  end

  // NOTE: the buffer RAM has no reset; loop_length==0 is what marks it empty.
  always_ff @(posedge AUD_BCLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[position];
  end

endmodule
